generic_skid_buffer: RTL
========================

# generic_skid_buffer

Two-entry valid/ready register slice for the common library. Its port-level storage is the backpressure-aware counterpart of the plain enable flop: an upstream writer pushes data with a valid/ready handshake and a downstream reader pops it. The slice breaks all combinational paths between the two sides and sustains one transfer per cycle. It is used to retime long valid/ready paths in trace and debug datapaths.

## Interface
- WIDTH, 8, data width in bits.
- RESET_VALUE, 0, value loaded into both data registers on reset, cast to WIDTH bits.
- clk  input  1  clock.
- rst_n  input  1  reset: synchronous, active-low.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  slice can accept; transfer when in_valid & in_ready.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  slice holds data for downstream.
- out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
- out_data  output  WIDTH  head-of-slice data.
- stall_cnt  output  16  stall counter; present only with SKID_BUF_STALL_CNT_EN.

## Operation
- Storage: main register (drives out_data) and skid register. The occupancy state is one of EMPTY, ONE or FULL.
- Signal definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - out_valid = (state != EMPTY).
  - in_ready = rst_n & (state != FULL).
- Transitions from EMPTY:
  - in_fire: main <= in_data; go to ONE.
  - Otherwise: stay.
- Transitions from ONE:
  - in_fire & !out_fire: skid <= in_data; go to FULL.
  - in_fire & out_fire: main <= in_data; stay in ONE.
  - !in_fire & out_fire: go to EMPTY.
  - Otherwise: hold.
- Transitions from FULL:
  - out_fire: main <= skid; go to ONE. in_fire is impossible because in_ready=0.
  - Otherwise: hold.
- Ordering is strictly FIFO. There is no loss and no duplication.
- out_data is stable while out_valid & !out_ready.
- out_data holds its last value when EMPTY.
- Upstream is required to hold in_valid and in_data until accepted. in_valid without in_ready is not a transfer.
- Data registers update only on the events listed above.

## Timing
- Reset values (rst_n low at a clk edge):
  - state = EMPTY, out_valid = 0.
  - main and skid = RESET_VALUE, so out_data = RESET_VALUE.
  - stall_cnt = 0.
- in_ready is 0 combinationally while rst_n is low. It becomes 1 in the first cycle after release.
- Latency is 1 cycle: data accepted at edge N is visible on out_data/out_valid after edge N.
- Throughput is 1 transfer/cycle when out_ready is held high. The skid entry is used only under backpressure.
- in_ready depends only on registered state and rst_n. There is no out_ready -> in_ready combinational path.
- out_valid and out_data are registered. There is no in_valid/in_data -> out combinational path.
- Reset mid-operation, in any state: the next state is EMPTY and all stored data is discarded.

## Configuration
- SKID_BUF_STALL_CNT_EN defined:
  - Adds the stall_cnt output, a 16-bit counter.
  - It increments each cycle with out_valid & !out_ready.
  - It saturates at 0xFFFF and is reset to 0 by rst_n.
- Not defined: the stall_cnt port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, RESET_VALUE=0x5A.
  - During reset: in_ready=0, out_valid=0, out_data=0x5A.
  - First cycle after release: in_ready=1.
- Streaming: out_ready=1, push 0x01..0x10 on consecutive cycles.
  - Each value appears on out_data one cycle after acceptance.
  - 16 transfers complete in 16 cycles and in_ready never drops.
- Backpressure: out_ready=0, offer 0xA1, 0xA2, 0xA3.
  - 0xA1 and 0xA2 are accepted; in_ready=0 after the second acceptance; 0xA3 is held.
  - Raise out_ready: out_data sequence is A1, A2, A3; in_ready returns the cycle after the first pop.
- Simultaneous fire: in state ONE holding 0x11, drive in_valid with 0x22 and out_ready=1 together.
  - 0x11 is popped, state stays ONE, and out_data=0x22 next cycle.
- Mid-operation reset: fill to FULL (0x33, 0x44), then pulse rst_n=0 for one cycle.
  - Result: out_valid=0, out_data=RESET_VALUE, in_ready=1 after release.
  - 0x33 and 0x44 never appear.
- Stall counter (with SKID_BUF_STALL_CNT_EN): out_valid=1, out_ready=0 for 70000 cycles.
  - stall_cnt reaches 0xFFFF and holds there.
  - Reset clears it to 0.

Source files
------------

// File: rtl/generic_skid_buffer.sv
// ============================================================================
// generic_skid_buffer
// ----------------------------------------------------------------------------
// Two-entry valid/ready register slice. Upstream pushes with in_valid/in_ready
// and downstream pops with out_valid/out_ready. Every output is derived only
// from registered state (plus rst_n for in_ready), so no combinational path
// crosses the slice. One transfer per cycle is sustained when out_ready is
// held high. The skid entry fills only under backpressure.
//
// Parameters
//   WIDTH        data width in bits
//   RESET_VALUE  value loaded into both data registers on reset
//
// Ports
//   clk        clock
//   rst_n      synchronous, active-low reset
//   in_valid   upstream data valid
//   in_ready   slice can accept (in_valid & in_ready = transfer)
//   in_data    upstream data
//   out_valid  slice holds data for downstream
//   out_ready  downstream accepts (out_valid & out_ready = transfer)
//   out_data   head-of-slice data
//   stall_cnt  saturating count of out_valid & !out_ready cycles
//              (only when SKID_BUF_STALL_CNT_EN is defined)
//
// Build option
//   SKID_BUF_STALL_CNT_EN  adds the 16-bit stall_cnt output and its counter
// ============================================================================
module generic_skid_buffer #(
    parameter int WIDTH       = 8,
    parameter     RESET_VALUE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SKID_BUF_STALL_CNT_EN
    ,
    output logic [15:0]      stall_cnt
`endif
);

    localparam logic [WIDTH-1:0] RST_DATA = WIDTH'(RESET_VALUE);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_p0;
    logic [WIDTH-1:0] main_p0;
    logic [WIDTH-1:0] skid_p0;
    logic             in_fire;
    logic             out_fire;

    assign in_ready  = rst_n & (state_p0 != FULL);
    assign out_valid = (state_p0 != EMPTY);
    assign out_data  = main_p0;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // ---- stage p0: occupancy state, head (main) and overflow (skid) storage ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0 <= EMPTY;
            main_p0  <= RST_DATA;
            skid_p0  <= RST_DATA;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (in_fire) begin
                        main_p0  <= in_data;
                        state_p0 <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && !out_fire) begin
                        skid_p0  <= in_data;
                        state_p0 <= FULL;
                    end else if (in_fire && out_fire) begin
                        main_p0  <= in_data;
                    end else if (out_fire) begin
                        state_p0 <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (out_fire) begin
                        main_p0  <= skid_p0;
                        state_p0 <= ONE;
                    end
                end
                default: begin
                    state_p0 <= EMPTY;
                end
            endcase
        end
    end

`ifdef SKID_BUF_STALL_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stall_cnt_p0;

    // ---- stage p0: stall counter ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_p0 <= 16'd0;
        end else if (out_valid && !out_ready) begin
            stall_cnt_p0 <= sat_inc16(stall_cnt_p0);
        end
    end

    assign stall_cnt = stall_cnt_p0;
`endif

endmodule
